dac_wave_ctrl: RTL and testbench

DAC_WAVE_CTRL -- requirements
Module: dac_wave_ctrl

---
 rtl/dac_wave_ctrl_if.sv | 25 ++
 rtl/dac_wave_ctrl.sv | 151 +++++++++++++++
 tb/tb_dac_wave_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_ctrl_if.sv
// Configuration handshake, enable level and DAC sample outputs for dac_wave_ctrl.
// The master drives configuration and enable. The slave (the controller) drives the DAC outputs and status.
interface dac_wave_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [7:0]       cfg_step;
  logic [7:0]       dac_out;
  logic             dac_wr;
  logic             busy;

  modport master (
    output enable, cfg_valid, cfg_mode, cfg_div, cfg_step,
    input  cfg_ready, dac_out, dac_wr, busy
  );

  modport slave (
    input  enable, cfg_valid, cfg_mode, cfg_div, cfg_step,
    output cfg_ready, dac_out, dac_wr, busy
  );
endinterface

// File: rtl/dac_wave_ctrl.sv
// Waveform generator for an 8-bit R-2R DAC: saw, triangle, square or constant level at a divided sample rate.
// A sample lands one clk after each divider tick. Configuration is accepted only while idle.
module dac_wave_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  dac_wave_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [1:0] MODE_SAW   = 2'd0;
  localparam logic [1:0] MODE_TRI   = 2'd1;
  localparam logic [1:0] MODE_SQR   = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       step_q, step_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_down_q, dir_down_d;
  logic             sq_low_q, sq_low_d;
  logic [7:0]       dac_out_q, dac_out_d;
  logic             dac_wr_q, dac_wr_d;

  logic             cfg_hs;
  logic             tick;
  logic [8:0]       sum9;

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dac_out   = dac_out_q;
  assign bus.dac_wr    = dac_wr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    acc_d      = acc_q;
    step_d     = step_q;
    mode_d     = mode_q;
    dir_down_d = dir_down_q;
    sq_low_d   = sq_low_q;
    dac_out_d  = dac_out_q;
    dac_wr_d   = 1'b0;
    tick       = 1'b0;
    cfg_hs     = bus.cfg_valid && (state_q == IDLE);
    sum9       = {1'b0, acc_q} + {1'b0, step_q};

    case (state_q)
      IDLE: begin
        // A config handshake wins over enable, so RUN always starts with the new settings.
        if (cfg_hs) begin
          mode_d = bus.cfg_mode;
          div_d  = bus.cfg_div;
          step_d = bus.cfg_step;
        end else if (bus.enable) begin
          state_d    = RUN;
          cnt_d      = '0;
          acc_d      = 8'd0;
          dir_down_d = 1'b0;
          sq_low_d   = 1'b0;
        end
      end

      RUN, STOP: begin
        tick  = (cnt_q == div_q);
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

        if (state_q == RUN) begin
          if (!bus.enable) state_d = STOP;
        end else begin
          if (bus.enable)  state_d = RUN;
          else if (tick)   state_d = IDLE;
        end

        if (tick) begin
          dac_wr_d = 1'b1;
          case (mode_q)
            MODE_SAW: begin
              acc_d     = sum9[7:0];
              dac_out_d = sum9[7:0];
            end
            MODE_TRI: begin
              if (!dir_down_q) begin
                if (sum9 >= 9'd255) begin
                  acc_d      = 8'd255;
                  dir_down_d = 1'b1;
                end else begin
                  acc_d = sum9[7:0];
                end
              end else begin
                if (acc_q <= step_q) begin
                  acc_d      = 8'd0;
                  dir_down_d = 1'b0;
                end else begin
                  acc_d = acc_q - step_q;
                end
              end
              dac_out_d = acc_d;
            end
            MODE_SQR: begin
              dac_out_d = sq_low_q ? 8'h00 : 8'hFF;
              sq_low_d  = ~sq_low_q;
            end
            MODE_CONST: begin
              dac_out_d = step_q;
            end
            default: begin
              dac_out_d = dac_out_q;
            end
          endcase
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      acc_q      <= 8'd0;
      step_q     <= 8'd1;
      mode_q     <= MODE_SAW;
      dir_down_q <= 1'b0;
      sq_low_q   <= 1'b0;
      dac_out_q  <= 8'h00;
      dac_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      dir_down_q <= dir_down_d;
      sq_low_q   <= sq_low_d;
      dac_out_q  <= dac_out_d;
      dac_wr_q   <= dac_wr_d;
    end
  end

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Directed bench for dac_wave_ctrl: stimulus pushes expected samples with the required spacing,
// and a monitor pops and compares them on every dac_wr strobe.
module tb_dac_wave_ctrl;

  localparam int DIV_W = 16;

  typedef struct {
    logic [7:0] val;
    int         gap;   // required cycles since previous write, 0 = not checked
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last_wr_cyc = 0;
  exp_t exp_q[$];

  dac_wave_ctrl_if #(.DIV_W(DIV_W)) bus ();

  dac_wave_ctrl #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] v, input int g);
    exp_t e;
    e.val = v;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // Returns just after the negedge on which the last expected sample was checked.
  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.dac_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", int'(bus.dac_out), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sample", int'(bus.dac_out), int'(e.val));
          if (e.gap != 0) chk("spacing", cyc - last_wr_cyc, e.gap);
        end
        last_wr_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    rst           = 1'b1;
    bus.enable    = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_div   = '0;
    bus.cfg_step  = 8'd0;
    step_cycles(2);
    chk("rst_dac_out", int'(bus.dac_out), 0);
    chk("rst_dac_wr", int'(bus.dac_wr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);

    // Default config: sawtooth step 1 every cycle, wrapping 255 -> 0
    for (int i = 1; i <= 258; i++) push(8'(i % 256), (i == 1) ? 0 : 1);
    rst = 1'b0;
    drain(300);
    bus.enable = 1'b0;
    push(8'd3, 1);
    push(8'd4, 1);
    drain(10);
    step_cycles(2);
    chk("t1_idle_busy", int'(bus.busy), 0);
    chk("t1_idle_hold", int'(bus.dac_out), 4);
    chk("t1_idle_wr", int'(bus.dac_wr), 0);
    chk("t1_idle_ready", int'(bus.cfg_ready), 1);

    // Saw div=3 step=100; handshake shares a cycle with enable and must win
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd0;
    bus.cfg_div   = 16'd3;
    bus.cfg_step  = 8'd100;
    bus.enable    = 1'b1;
    push(8'd100, 0);
    push(8'd200, 4);
    push(8'd44, 4);
    push(8'd144, 4);
    step_cycles(1);
    chk("t2_hs_stays_idle", int'(bus.busy), 0);
    bus.cfg_valid = 1'b0;
    drain(40);

    // Config offered during RUN is ignored; STOP->RUN keeps the cadence
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd3;
    bus.cfg_div   = 16'd0;
    bus.cfg_step  = 8'd7;
    bus.enable    = 1'b0;
    #1;
    chk("t2_run_ready", int'(bus.cfg_ready), 0);
    step_cycles(1);
    chk("t2_stop_busy", int'(bus.busy), 1);
    chk("t2_stop_ready", int'(bus.cfg_ready), 0);
    bus.enable    = 1'b1;
    bus.cfg_valid = 1'b0;
    push(8'd244, 4);
    push(8'd88, 4);
    push(8'd188, 4);
    drain(40);
    bus.enable = 1'b0;
    push(8'd32, 4);
    drain(20);
    step_cycles(1);
    chk("t2_end_busy", int'(bus.busy), 0);

    // Triangle div=0 step=100
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd1;
    bus.cfg_div   = 16'd0;
    bus.cfg_step  = 8'd100;
    step_cycles(1);
    bus.cfg_valid = 1'b0;
    bus.enable    = 1'b1;
    push(8'd100, 0);
    push(8'd200, 1);
    push(8'd255, 1);
    push(8'd155, 1);
    push(8'd55, 1);
    push(8'd0, 1);
    push(8'd100, 1);
    drain(20);
    bus.enable = 1'b0;
    push(8'd200, 1);
    push(8'd255, 1);
    drain(10);

    // Square div=1; enable drops right after a sample, leaving one final sample
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd2;
    bus.cfg_div   = 16'd1;
    bus.cfg_step  = 8'd100;
    step_cycles(1);
    bus.cfg_valid = 1'b0;
    bus.enable    = 1'b1;
    push(8'hFF, 0);
    push(8'h00, 2);
    push(8'hFF, 2);
    drain(20);
    bus.enable = 1'b0;
    push(8'h00, 2);
    drain(10);
    for (int i = 0; i < 3; i++) begin
      step_cycles(1);
      chk("t4_idle_busy", int'(bus.busy), 0);
      chk("t4_idle_hold", int'(bus.dac_out), 0);
      chk("t4_idle_wr", int'(bus.dac_wr), 0);
    end

    // Reset mid-RUN clears outputs at once and restores the default config
    bus.enable = 1'b1;
    push(8'hFF, 0);
    push(8'h00, 2);
    push(8'hFF, 2);
    drain(20);
    rst = 1'b1;
    #1;
    chk("t5_rst_dac_out", int'(bus.dac_out), 0);
    chk("t5_rst_dac_wr", int'(bus.dac_wr), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    step_cycles(2);
    chk("t5_rst_ready", int'(bus.cfg_ready), 1);
    push(8'd1, 0);
    push(8'd2, 1);
    push(8'd3, 1);
    rst = 1'b0;
    drain(20);
    bus.enable = 1'b0;
    push(8'd4, 1);
    push(8'd5, 1);
    drain(10);
    step_cycles(3);
    chk("t5_end_busy", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
